// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the five-stage R/I/J CPU.
//   REG_W      register-index width
//   ADDR_W     instruction address width
//   ZERO_REG   index of the hard-wired zero register
//   hz_state_t hazard controller FSM encoding
package cpu_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned ADDR_W = 32;

    localparam logic [REG_W-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        MDU_WAIT = 2'd2
    } hz_state_t;

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use comparator.
// Flags an ID instruction that reads the destination of a load currently in EX.
// Loads to the zero register never create a dependency.
// Ports:
//   ex_is_load, ex_rd            load in EX and its destination
//   id_rs, id_rt                 ID source registers
//   id_uses_rs, id_uses_rt       ID instruction actually reads that source
//   ld_haz                       load-use hazard
module hazard_detect
    import cpu_pkg::*;
(
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    output logic             ld_haz
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = id_uses_rs && (id_rs == ex_rd);
    assign rt_hit = id_uses_rt && (id_rt == ex_rd);
    assign ld_haz = ex_is_load && (ex_rd != ZERO_REG) && (rs_hit || rt_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and redirect controller.
// Decides each cycle whether fetch advances, stalls or is redirected, and drives
// the IF/ID flush and ID/EX bubble controls. Priority: taken branch in EX,
// load-use, MDU read while busy, resolved jump in ID.
// Build option: define HAZARD_CTRL_MDU_EN to enable the MDU wait state, its
// wait counter and the sticky timeout flag; otherwise id_mdu_read/mdu_busy are
// ignored and err is tied low.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   id_rs/id_rt/id_uses_rs/id_uses_rt  ID source operands
//   id_mdu_read                     ID is mfhi/mflo
//   id_jump, id_jump_target         resolved jump in ID
//   ex_is_load, ex_rd               load in EX
//   ex_br_taken, ex_br_target       taken branch in EX
//   mdu_busy                        MDU operation in flight
//   stall, cond, condNPC            fetch controls (combinational)
//   flush_id, bubble_ex             pipeline register controls (combinational)
//   stall_cnt, redir_cnt            saturating event counters
//   err                             sticky MDU timeout
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned MDU_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_mdu_read,
    input  logic              id_jump,
    input  logic [ADDR_W-1:0] id_jump_target,
    input  logic              ex_is_load,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              ex_br_taken,
    input  logic [ADDR_W-1:0] ex_br_target,
    input  logic              mdu_busy,
    output logic              stall,
    output logic              cond,
    output logic [ADDR_W-1:0] condNPC,
    output logic              flush_id,
    output logic              bubble_ex,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  redir_cnt,
    output logic              err
);

    localparam int unsigned WAIT_W = $clog2(MDU_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MDU_TIMEOUT);

    hz_state_t state_q, state_d;

    logic              ld_haz;
    logic              mdu_busy_en;
    logic              mdu_read_en;
    logic              wait_inc;
    logic              wait_clr;
    logic [ADDR_W-1:0] cond_npc;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  redir_cnt_q;

    hazard_detect u_detect (
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rs (id_uses_rs),
        .id_uses_rt (id_uses_rt),
        .ld_haz     (ld_haz)
    );

`ifdef HAZARD_CTRL_MDU_EN
    assign mdu_busy_en = mdu_busy;
    assign mdu_read_en = id_mdu_read;
`else
    assign mdu_busy_en = 1'b0;
    assign mdu_read_en = 1'b0;
`endif

    // Next state and fetch/pipeline controls. Every branch below applies the RUN
    // rules, except that LD_STALL masks the load-use check (the load has moved
    // to MEM) and MDU_WAIT holds while the MDU is busy.
    always_comb begin
        state_d   = RUN;
        stall     = 1'b0;
        cond      = 1'b0;
        cond_npc  = '0;
        flush_id  = 1'b0;
        bubble_ex = 1'b0;
        wait_inc  = 1'b0;
        wait_clr  = 1'b0;

        if (ex_br_taken) begin
            // ID holds a wrong-path instruction, so its hazards do not matter.
            cond      = 1'b1;
            cond_npc  = ex_br_target;
            flush_id  = 1'b1;
            bubble_ex = 1'b1;
        end else if ((state_q == MDU_WAIT) && mdu_busy_en) begin
            stall     = 1'b1;
            bubble_ex = 1'b1;
            wait_inc  = 1'b1;
            state_d   = MDU_WAIT;
        end else if ((state_q != LD_STALL) && ld_haz) begin
            stall     = 1'b1;
            bubble_ex = 1'b1;
            // Leaving MDU_WAIT always returns to RUN, even on a load-use stall.
            if (state_q == RUN) begin
                state_d = LD_STALL;
            end
        end else if (mdu_read_en && mdu_busy_en) begin
            stall     = 1'b1;
            bubble_ex = 1'b1;
            wait_clr  = 1'b1;
            state_d   = MDU_WAIT;
        end else if (id_jump) begin
            cond     = 1'b1;
            cond_npc = id_jump_target;
            flush_id = 1'b1;
        end
    end

    assign condNPC = cond_npc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            if (stall && !(&stall_cnt_q)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (cond && !(&redir_cnt_q)) begin
                redir_cnt_q <= redir_cnt_q + 1'b1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign redir_cnt = redir_cnt_q;

`ifdef HAZARD_CTRL_MDU_EN
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              err_q;

    // Saturates at the timeout so the flag can never be missed by wrap-around.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (wait_clr) begin
            wait_cnt_d = '0;
        end else if (wait_inc && (wait_cnt_q != WAIT_MAX)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            if (wait_cnt_d == WAIT_MAX) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    logic unused_mdu;
    assign unused_mdu = ^{id_mdu_read, mdu_busy, wait_inc, wait_clr, WAIT_MAX};
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: self-checking bench for hazard_ctrl.
// A behavioural model (pipeline mode, event tallies, sticky timeout) predicts
// every output each cycle; directed sequences pin the model with literals, then
// randomized traffic with biased register collisions runs against it.
// Honours HAZARD_CTRL_MDU_EN the same way as the design.
module tb_hazard_ctrl;

    localparam int unsigned TIMEOUT = 64;
    localparam int unsigned CW      = 8;
    localparam int          SAT     = (1 << CW) - 1;
`ifdef HAZARD_CTRL_MDU_EN
    localparam bit MDU_EN = 1'b1;
`else
    localparam bit MDU_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    id_rs, id_rt, ex_rd;
    logic          id_uses_rs, id_uses_rt, id_mdu_read, id_jump;
    logic [31:0]   id_jump_target, ex_br_target;
    logic          ex_is_load, ex_br_taken, mdu_busy;
    logic          stall, cond, flush_id, bubble_ex, err;
    logic [31:0]   condNPC;
    logic [CW-1:0] stall_cnt, redir_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .MDU_TIMEOUT (TIMEOUT),
        .CNT_W       (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rs     (id_uses_rs),
        .id_uses_rt     (id_uses_rt),
        .id_mdu_read    (id_mdu_read),
        .id_jump        (id_jump),
        .id_jump_target (id_jump_target),
        .ex_is_load     (ex_is_load),
        .ex_rd          (ex_rd),
        .ex_br_taken    (ex_br_taken),
        .ex_br_target   (ex_br_target),
        .mdu_busy       (mdu_busy),
        .stall          (stall),
        .cond           (cond),
        .condNPC        (condNPC),
        .flush_id       (flush_id),
        .bubble_ex      (bubble_ex),
        .stall_cnt      (stall_cnt),
        .redir_cnt      (redir_cnt),
        .err            (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_mode: 0 normal, 1 cycle after a load-use stall, 2 waiting on the MDU
    int m_mode, m_waited, m_stalls, m_redirs;
    bit m_err, mvalid;
    bit e_stall, e_cond, e_flush, e_bub;
    logic [31:0] e_npc;
    int nm;

    function automatic bit load_use();
        bit reads_rd;
        reads_rd = (id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd);
        return ex_is_load && (ex_rd != 5'd0) && reads_rd;
    endfunction

    always @(negedge clk) begin
        if (mvalid) begin
            e_stall = 0; e_cond = 0; e_flush = 0; e_bub = 0; e_npc = 32'h0; nm = 0;
            if (ex_br_taken) begin
                e_cond = 1; e_npc = ex_br_target; e_flush = 1; e_bub = 1;
            end else if (MDU_EN && m_mode == 2 && mdu_busy) begin
                e_stall = 1; e_bub = 1; nm = 2;
            end else if (m_mode != 1 && load_use()) begin
                e_stall = 1; e_bub = 1; nm = (m_mode == 0) ? 1 : 0;
            end else if (MDU_EN && id_mdu_read && mdu_busy) begin
                e_stall = 1; e_bub = 1; nm = 2;
            end else if (id_jump) begin
                e_cond = 1; e_npc = id_jump_target; e_flush = 1;
            end
            chk("stall", {31'b0, stall}, {31'b0, e_stall});
            chk("cond", {31'b0, cond}, {31'b0, e_cond});
            chk("condNPC", condNPC, e_npc);
            chk("flush_id", {31'b0, flush_id}, {31'b0, e_flush});
            chk("bubble_ex", {31'b0, bubble_ex}, {31'b0, e_bub});
            chk("stall_cnt", 32'(stall_cnt), 32'(m_stalls));
            chk("redir_cnt", 32'(redir_cnt), 32'(m_redirs));
            chk("err", {31'b0, err}, {31'b0, m_err});
            // advance to the state after the coming rising edge
            if (nm == 2) m_waited = (m_mode == 2) ? m_waited + 1 : 0;
            if (m_waited >= int'(TIMEOUT)) m_err = 1;
            if (e_stall && m_stalls < SAT) m_stalls++;
            if (e_cond && m_redirs < SAT) m_redirs++;
            m_mode = nm;
        end
        if (rst) begin
            m_mode = 0; m_waited = 0; m_stalls = 0; m_redirs = 0; m_err = 0;
            mvalid = 1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
        id_uses_rs = 0; id_uses_rt = 0; id_mdu_read = 0; id_jump = 0;
        id_jump_target = 32'h0; ex_br_target = 32'h0;
        ex_is_load = 0; ex_br_taken = 0; mdu_busy = 0;
    endtask

    initial begin
        int n;
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        mid();
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_cond", {31'b0, cond}, 32'd0);
        chk("rst_npc", condNPC, 32'd0);
        chk("rst_flush", {31'b0, flush_id}, 32'd0);
        chk("rst_bubble", {31'b0, bubble_ex}, 32'd0);
        chk("rst_cnts", 32'(stall_cnt) | 32'(redir_cnt), 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);

        // load-use: one stall cycle, then released
        cyc();
        ex_is_load = 1; ex_rd = 5'd5; id_rs = 5'd5; id_uses_rs = 1;
        mid();
        chk("lu_stall", {31'b0, stall}, 32'd1);
        chk("lu_bubble", {31'b0, bubble_ex}, 32'd1);
        cyc();
        mid();
        chk("lu_release", {31'b0, stall}, 32'd0);
        cyc();
        idle();
        mid();
        chk("lu_cnt", 32'(stall_cnt), 32'd1);

        // load to r0 never stalls
        cyc();
        ex_is_load = 1; ex_rd = 5'd0; id_rt = 5'd0; id_uses_rt = 1;
        mid();
        chk("r0_nostall", {31'b0, stall}, 32'd0);

        // taken branch beats a load-use hazard
        cyc();
        idle();
        ex_br_taken = 1; ex_br_target = 32'h40;
        ex_is_load = 1; ex_rd = 5'd5; id_rs = 5'd5; id_uses_rs = 1;
        mid();
        chk("br_cond", {31'b0, cond}, 32'd1);
        chk("br_npc", condNPC, 32'h40);
        chk("br_flush", {31'b0, flush_id}, 32'd1);
        chk("br_stall", {31'b0, stall}, 32'd0);
        cyc();
        idle();
        mid();
        chk("br_redir", 32'(redir_cnt), 32'd1);

        // mfhi while MDU busy for four cycles
        cyc();
        id_mdu_read = 1; mdu_busy = 1;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            mid();
            if (stall) n++;
            cyc();
        end
        mdu_busy = 0;
        mid();
        chk("mdu4_len", 32'(n), MDU_EN ? 32'd4 : 32'd0);
        chk("mdu4_done", {31'b0, stall}, 32'd0);
        chk("mdu4_err", {31'b0, err}, 32'd0);

        // MDU timeout, then reset in the middle of the stall
        cyc();
        idle();
        cyc();
        id_mdu_read = 1; mdu_busy = 1;
        for (int i = 1; i <= 70; i++) begin
            mid();
            if (i == 60) chk("to_early", {31'b0, err}, 32'd0);
            if (i == 70) chk("to_err", {31'b0, err}, {31'b0, MDU_EN});
            cyc();
        end
        rst = 1;
        cyc();
        rst = 0;
        idle();
        mid();
        chk("to_rst_err", {31'b0, err}, 32'd0);
        chk("to_rst_stall", {31'b0, stall}, 32'd0);
        chk("to_rst_cnt", 32'(stall_cnt), 32'd0);

        // jr with load-use: stall first, jump when re-presented
        cyc();
        ex_is_load = 1; ex_rd = 5'd7; id_rs = 5'd7; id_uses_rs = 1;
        id_jump = 1; id_jump_target = 32'h100;
        mid();
        chk("jr_stall", {31'b0, stall}, 32'd1);
        chk("jr_nocond", {31'b0, cond}, 32'd0);
        cyc();
        mid();
        chk("jr_cond", {31'b0, cond}, 32'd1);
        chk("jr_npc", condNPC, 32'h100);
        chk("jr_nostall", {31'b0, stall}, 32'd0);
        cyc();
        idle();

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rst            = ($urandom_range(0, 1499) == 0);
            id_rs          = 5'($urandom_range(0, 3));
            id_rt          = 5'($urandom_range(0, 3));
            ex_rd          = 5'($urandom_range(0, 3));
            id_uses_rs     = $urandom_range(0, 1) == 1;
            id_uses_rt     = $urandom_range(0, 1) == 1;
            ex_is_load     = $urandom_range(0, 2) == 0;
            ex_br_taken    = $urandom_range(0, 7) == 0;
            id_jump        = $urandom_range(0, 5) == 0;
            id_mdu_read    = $urandom_range(0, 3) == 0;
            id_jump_target = $urandom;
            ex_br_target   = $urandom;
            if (mdu_busy) mdu_busy = $urandom_range(0, 4) != 0;
            else          mdu_busy = $urandom_range(0, 3) == 0;
            cyc();
        end
        rst = 0;
        idle();
        mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
